// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the multi-channel PWM generator
package pwm_pkg;
    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    function automatic int duty_width(input int steps);
        return $clog2(steps + 1);
    endfunction
endpackage

// File: rtl/pwm_btn_debounce.sv
// pwm_btn_debounce: tick-rate two-stage sampler with a one-cycle rising-edge pulse
module pwm_btn_debounce (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);
    logic s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        s1_d  = tick ? btn : s1_q;
        s2_d  = tick ? s1_q : s2_q;
        press = s1_q & ~s2_q & tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: NCH button-controlled PWM channels sharing one period counter,
// with duties and mode shadowed into the active set only at period boundaries
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int STEPS     = 10,
    parameter int DW        = duty_width(STEPS),
    parameter int DEB_DIV   = 25000000,
    parameter int DUTY_INIT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              center_mode,
    input  logic [NCH-1:0]    inc_btn,
    input  logic [NCH-1:0]    dec_btn,
    output logic [NCH-1:0]    pwm_out,
    output logic [NCH*DW-1:0] duty_out,
    output logic              period_start
);
    localparam int PW = $clog2(2 * STEPS);
    localparam int CW = $clog2(DEB_DIV);

    logic [CW-1:0]          deb_cnt_q, deb_cnt_d;
    logic [PW-1:0]          pc_q, pc_d, level, lim;
    logic [NCH-1:0][DW-1:0] duty_req_q, duty_req_d, duty_act_q, duty_act_d;
    logic [NCH-1:0]         pwm_q, pwm_d, inc_p, dec_p;
    logic                   mode_act_q, mode_act_d, period_start_q, period_start_d;
    logic                   tick, boundary, load;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_btn_debounce u_inc (.clk(clk), .rst(rst), .tick(tick), .btn(inc_btn[i]), .press(inc_p[i]));
        pwm_btn_debounce u_dec (.clk(clk), .rst(rst), .tick(tick), .btn(dec_btn[i]), .press(dec_p[i]));
    end

    always_comb begin
        tick           = deb_cnt_q == CW'(DEB_DIV - 1);
        deb_cnt_d      = tick ? '0 : deb_cnt_q + 1'b1;
        lim            = (mode_act_q == PWM_CENTER) ? PW'(2 * STEPS - 1) : PW'(STEPS - 1);
        boundary       = pc_q == lim;
        // while disabled the shadow copy tracks the requests every cycle
        load           = !ena || boundary;
        pc_d           = load ? '0 : pc_q + 1'b1;
        mode_act_d     = load ? center_mode : mode_act_q;
        duty_act_d     = load ? duty_req_q : duty_act_q;
        level          = (mode_act_q == PWM_CENTER && pc_q >= PW'(STEPS)) ? PW'(2 * STEPS - 1) - pc_q : pc_q;
        period_start_d = ena && pc_q == '0;
        for (int k = 0; k < NCH; k++) begin
            duty_req_d[k] = duty_req_q[k];
            if (inc_p[k] && !dec_p[k] && duty_req_q[k] < DW'(STEPS))
                duty_req_d[k] = duty_req_q[k] + 1'b1;
            else if (dec_p[k] && !inc_p[k] && duty_req_q[k] > '0)
                duty_req_d[k] = duty_req_q[k] - 1'b1;
            pwm_d[k] = ena && (level < PW'(duty_act_q[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_q      <= '0;
            pc_q           <= '0;
            duty_req_q     <= {NCH{DW'(DUTY_INIT)}};
            duty_act_q     <= {NCH{DW'(DUTY_INIT)}};
            mode_act_q     <= PWM_EDGE;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            deb_cnt_q      <= deb_cnt_d;
            pc_q           <= pc_d;
            duty_req_q     <= duty_req_d;
            duty_act_q     <= duty_act_d;
            mode_act_q     <= mode_act_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign duty_out     = duty_act_q;
    assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed checks of duty stepping, shadowing, modes, enable and reset
module tb_pwm_multi_channel;
    logic       clk = 1'b0;
    logic       rst, ena, center_mode, period_start;
    logic [1:0] inc_btn, dec_btn, pwm_out;
    logic [7:0] duty_out;
    logic [19:0] p0, p1;
    int         nps;
    int         n_pass = 0;
    int         n_chk  = 0;

    always #5 clk = ~clk;

    pwm_multi_channel #(.NCH(2), .STEPS(10), .DEB_DIV(2), .DUTY_INIT(5)) dut (
        .clk(clk), .rst(rst), .ena(ena), .center_mode(center_mode),
        .inc_btn(inc_btn), .dec_btn(dec_btn), .pwm_out(pwm_out),
        .duty_out(duty_out), .period_start(period_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int ch, input logic inc, input logic dec);
        inc_btn[ch] = inc;
        dec_btn[ch] = dec;
        cyc(4);
        inc_btn[ch] = 1'b0;
        dec_btn[ch] = 1'b0;
        cyc(4);
    endtask

    task automatic next_period();
        cyc(3);
        for (int i = 0; i < 50 && !period_start; i++) cyc(1);
        chk("period_start_seen", period_start, 1);
    endtask

    task automatic measure(input int len);
        p0  = '0;
        p1  = '0;
        nps = 0;
        for (int k = 0; k < len; k++) begin
            p0[k] = pwm_out[0];
            p1[k] = pwm_out[1];
            nps += period_start;
            cyc(1);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; center_mode = 1'b0; inc_btn = '0; dec_btn = '0;
        cyc(3);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_duty", duty_out, 8'h55);
        rst = 1'b0;
        cyc(1);
        chk("first_ps", period_start, 1);
        chk("first_pwm", pwm_out, 2'b11);
        measure(10);
        chk("edge5_ch0", p0, 20'h0001F);
        chk("edge5_ch1", p1, 20'h0001F);
        chk("edge_nps", nps, 1);
        chk("edge_period", period_start, 1);

        repeat (7) press(0, 1'b1, 1'b0);
        next_period();
        measure(10);
        chk("sat_hi_ch0", p0, 20'h003FF);
        chk("sat_hi_ch1", p1, 20'h0001F);
        chk("sat_hi_duty", duty_out, 8'h5A);

        repeat (7) press(1, 1'b0, 1'b1);
        next_period();
        measure(10);
        chk("sat_lo_ch1", p1, 20'h0);
        chk("sat_lo_duty", duty_out, 8'h0A);

        repeat (5) press(0, 1'b0, 1'b1);
        press(0, 1'b1, 1'b1);
        next_period();
        chk("both_duty", duty_out, 8'h05);

        p0 = '0;
        for (int k = 0; k < 10; k++) begin
            p0[k] = pwm_out[0];
            if (k == 1) inc_btn[0] = 1'b1;
            if (k == 5) inc_btn[0] = 1'b0;
            cyc(1);
        end
        chk("mid_unchanged", p0, 20'h0001F);
        chk("mid_ps", period_start, 1);
        measure(10);
        chk("mid_applied", p0, 20'h0003F);
        chk("mid_duty", duty_out, 8'h06);

        repeat (3) press(0, 1'b0, 1'b1);
        center_mode = 1'b1;
        next_period();
        measure(20);
        chk("center_ch0", p0, 20'hE0007);
        chk("center_ch1", p1, 20'h0);
        chk("center_nps", nps, 1);
        chk("center_period", period_start, 1);

        cyc(1);
        chk("center_mid_hi", pwm_out, 2'b01);
        ena = 1'b0;
        cyc(1);
        chk("dis_pwm", pwm_out, 0);
        chk("dis_ps", period_start, 0);
        center_mode = 1'b0;
        cyc(3);
        chk("dis_hold", {period_start, pwm_out}, 0);
        ena = 1'b1;
        cyc(1);
        chk("ena_ps", period_start, 1);
        measure(10);
        chk("ena_edge_ch0", p0, 20'h00007);
        chk("ena_edge_period", period_start, 1);
        chk("ena_duty", duty_out, 8'h03);

        cyc(4);
        rst = 1'b1;
        cyc(1);
        chk("mrst_pwm", pwm_out, 0);
        chk("mrst_ps", period_start, 0);
        chk("mrst_duty", duty_out, 8'h55);
        rst = 1'b0;
        cyc(1);
        chk("mrst_restart", {period_start, pwm_out}, 3'b111);
        measure(10);
        chk("mrst_ch0", p0, 20'h0001F);
        chk("mrst_ch1", p1, 20'h0001F);
        chk("mrst_period", period_start, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
